// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle MSB-first magnitude comparator.
// Compares two WIDTH-bit operands DIGIT bits per clock, with an optional early
// exit on the first differing digit. Signed mode flips both sign bits at capture
// (offset binary), so the digit-serial compare is always unsigned.
module comparator_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIGIT      = 1,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_less_B
);

    localparam int unsigned NDIG     = WIDTH / DIGIT;
    localparam int unsigned IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    // Flag vector layout: {greater, equal, less}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             diff_q, diff_d;   // a differing digit has been seen
    logic             gt_q, gt_d;       // outcome of that first differing digit
    logic [2:0]       flags_q, flags_d;

    logic [WIDTH-1:0] sign_flip;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_differ;
    logic             dig_gt;
    logic             last_dig;

    // Operands are shifted left each cycle, so the current digit is always the top slice.
    assign sign_flip  = {signed_mode, {(WIDTH-1){1'b0}}};
    assign dig_a      = a_q[WIDTH-1 -: DIGIT];
    assign dig_b      = b_q[WIDTH-1 -: DIGIT];
    assign dig_differ = (dig_a != dig_b);
    assign dig_gt     = (dig_a > dig_b);
    assign last_dig   = (idx_q == LAST_IDX);

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= 1'b0;
            gt_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            gt_q    <= gt_d;
            flags_q <= flags_d;
        end
    end

    // Next-state, digit stepping and result selection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        gt_d    = gt_q;
        flags_d = flags_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A ^ sign_flip;
                    b_d     = B ^ sign_flip;
                    idx_d   = '0;
                    diff_d  = 1'b0;
                    gt_d    = 1'b0;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                idx_d = idx_q + IW'(1);
                if (EARLY_EXIT != 0) begin
                    if (dig_differ) begin
                        flags_d = dig_gt ? RES_GT : RES_LT;
                        state_d = DONE;
                    end else if (last_dig) begin
                        flags_d = RES_EQ;
                        state_d = DONE;
                    end
                end else begin
                    // Only the first differing digit decides; later digits are ignored.
                    if (dig_differ && !diff_q) begin
                        diff_d = 1'b1;
                        gt_d   = dig_gt;
                    end
                    if (last_dig) begin
                        if (diff_q) begin
                            flags_d = gt_q ? RES_GT : RES_LT;
                        end else if (dig_differ) begin
                            flags_d = dig_gt ? RES_GT : RES_LT;
                        end else begin
                            flags_d = RES_EQ;
                        end
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == COMPARE);
    assign done        = (state_q == DONE);
    assign A_greater_B = flags_q[2];
    assign A_equal_B   = flags_q[1];
    assign A_less_B    = flags_q[0];

endmodule

// File: tb/tb_comparator_seq.sv
// Testbench for comparator_seq: two instances (8/1/early-exit and 12/4/fixed
// latency) checked against a value-level reference model.
module tb_comparator_seq;

    logic clk;
    logic rst_n;

    logic        start0, sm0;
    logic [7:0]  a0, b0;
    logic        busy0, done0, gt0, eq0, lt0;

    logic        start1, sm1;
    logic [11:0] a1, b1;
    logic        busy1, done1, gt1, eq1, lt1;

    int n_checks;
    int n_fail;

    comparator_seq #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0),
        .A(a0), .B(b0), .busy(busy0), .done(done0),
        .A_greater_B(gt0), .A_equal_B(eq0), .A_less_B(lt0)
    );

    comparator_seq #(.WIDTH(12), .DIGIT(4), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1),
        .A(a1), .B(b1), .busy(busy1), .done(done1),
        .A_greater_B(gt1), .A_equal_B(eq1), .A_less_B(lt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: compare values arithmetically; latency from the highest differing bit.
    function automatic void model(input int w, input int d, input int ee,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input bit sm, output int lat, output logic [2:0] fl);
        longint va, vb;
        logic [31:0] x;
        int p;
        va = longint'(a);
        vb = longint'(b);
        if (sm && a[w-1]) va = va - (longint'(1) << w);
        if (sm && b[w-1]) vb = vb - (longint'(1) << w);
        if (va > vb)       fl = 3'b100;
        else if (va == vb) fl = 3'b010;
        else               fl = 3'b001;
        x = a ^ b;
        lat = w / d;
        if (ee != 0 && x != 0) begin
            p = 0;
            for (int i = 0; i < w; i++) if (x[i]) p = i;
            lat = (w - 1 - p) / d + 1;
        end
    endfunction

    // Issue one operation on dut0; optionally pokes start mid-operation.
    task automatic op0(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit poke,
                       output int lat, output int bcnt, output logic [2:0] fl,
                       output logic busy_at_done);
        @(negedge clk);
        a0 = a; b0 = b; sm0 = sm; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); sm0 = 1'($urandom);
        lat = -1; fl = 3'bxxx; busy_at_done = 1'bx;
        bcnt = busy0 ? 1 : 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (done0) begin
                lat = k; fl = {gt0, eq0, lt0}; busy_at_done = busy0;
                break;
            end
            if (busy0) bcnt++;
            if (poke && k == 3) begin start0 = 1'b1; a0 = 8'h00; b0 = 8'hFF; sm0 = 1'b0; end
            if (k == 4) start0 = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Issue one operation on dut1.
    task automatic op1(input logic [11:0] a, input logic [11:0] b, input bit sm,
                       output int lat, output logic [2:0] fl);
        @(negedge clk);
        a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = 12'($urandom); b1 = 12'($urandom); sm1 = 1'($urandom);
        lat = -1; fl = 3'bxxx;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (done1) begin
                lat = k; fl = {gt1, eq1, lt1};
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 1'b1; sm0 = 1'b0; a0 = 8'h12; b0 = 8'h34;
        start1 = 1'b1; sm1 = 1'b0; a1 = 12'h123; b1 = 12'h456;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy0, done0, gt0, eq0, lt0} !== 5'b0) begin
            n_fail++; $display("FAIL reset_dut0 got %b expected 00000", {busy0, done0, gt0, eq0, lt0});
        end
        n_checks++;
        if ({busy1, done1, gt1, eq1, lt1} !== 5'b0) begin
            n_fail++; $display("FAIL reset_dut1 got %b expected 00000", {busy1, done1, gt1, eq1, lt1});
        end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed_early();
        int lat, bcnt; logic [2:0] fl; logic bd;
        op0(8'h00, 8'h01, 1'b0, 1'b0, lat, bcnt, fl, bd);
        n_checks++;
        if (fl !== 3'b001) begin n_fail++; $display("FAIL lt_00_01 flags got %b expected 001", fl); end
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL lat_00_01 got %0d expected 8", lat); end
        n_checks++;
        if (bcnt !== 8) begin n_fail++; $display("FAIL busy_cycles_00_01 got %0d expected 8", bcnt); end
        n_checks++;
        if (bd !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %b expected 0", bd); end

        op0(8'h80, 8'h7F, 1'b0, 1'b0, lat, bcnt, fl, bd);
        n_checks++;
        if (fl !== 3'b100 || lat !== 1) begin
            n_fail++; $display("FAIL unsigned_80_7F flags %b lat %0d expected 100 lat 1", fl, lat);
        end
        op0(8'h80, 8'h7F, 1'b1, 1'b0, lat, bcnt, fl, bd);
        n_checks++;
        if (fl !== 3'b001 || lat !== 1) begin
            n_fail++; $display("FAIL signed_80_7F flags %b lat %0d expected 001 lat 1", fl, lat);
        end
    endtask

    task automatic test_hold_and_ignore();
        int lat, bcnt, extra; logic [2:0] fl; logic bd;
        op0(8'h5A, 8'h5A, 1'b0, 1'b0, lat, bcnt, fl, bd);
        n_checks++;
        if (fl !== 3'b010 || lat !== 8) begin
            n_fail++; $display("FAIL eq_5A flags %b lat %0d expected 010 lat 8", fl, lat);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({gt0, eq0, lt0} !== 3'b010) begin
            n_fail++; $display("FAIL hold_idle flags %b expected 010", {gt0, eq0, lt0});
        end
        op0(8'h01, 8'h00, 1'b0, 1'b1, lat, bcnt, fl, bd);
        n_checks++;
        if (fl !== 3'b100 || lat !== 8) begin
            n_fail++; $display("FAIL gt_01_00_poked flags %b lat %0d expected 100 lat 8", fl, lat);
        end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done0 || busy0) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL queued_start activity cycles %0d expected 0", extra); end
    endtask

    task automatic test_wide_fixed();
        int lat; logic [2:0] fl;
        op1(12'h800, 12'h0FF, 1'b0, lat, fl);
        n_checks++;
        if (fl !== 3'b100 || lat !== 3) begin
            n_fail++; $display("FAIL w12_800_0FF flags %b lat %0d expected 100 lat 3", fl, lat);
        end
        op1(12'hFFF, 12'h001, 1'b1, lat, fl);
        n_checks++;
        if (fl !== 3'b001 || lat !== 3) begin
            n_fail++; $display("FAIL w12_signed_FFF_001 flags %b lat %0d expected 001 lat 3", fl, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bcnt, seen; logic [2:0] fl; logic bd;
        @(negedge clk);
        a0 = 8'h00; b0 = 8'h01; sm0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy0, done0, gt0, eq0, lt0} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid got %b expected 00000", {busy0, done0, gt0, eq0, lt0});
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done0) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done0 || busy0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abandoned_op activity %0d expected 0", seen); end
        op0(8'h03, 8'h03, 1'b0, 1'b0, lat, bcnt, fl, bd);
        n_checks++;
        if (fl !== 3'b010 || lat !== 8) begin
            n_fail++; $display("FAIL post_reset_eq flags %b lat %0d expected 010 lat 8", fl, lat);
        end
    endtask

    task automatic test_random();
        int lat, bcnt, elat; logic [2:0] fl, efl; logic bd;
        logic [7:0] ra, rb; logic [11:0] wa, wb; bit sm;
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom); rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            sm = 1'($urandom);
            model(8, 1, 1, 32'(ra), 32'(rb), sm, elat, efl);
            op0(ra, rb, sm, 1'b0, lat, bcnt, fl, bd);
            n_checks++;
            if (fl !== efl || lat !== elat || bcnt !== elat) begin
                n_fail++;
                $display("FAIL rand8 a=%h b=%h s=%0d flags %b lat %0d busy %0d expected %b lat %0d",
                         ra, rb, sm, fl, lat, bcnt, efl, elat);
            end
        end
        for (int n = 0; n < 40; n++) begin
            wa = 12'($urandom);
            case ($urandom_range(0, 3))
                0: wb = wa;
                1: wb = wa ^ 12'h001;
                default: wb = 12'($urandom);
            endcase
            sm = 1'($urandom);
            model(12, 4, 0, 32'(wa), 32'(wb), sm, elat, efl);
            op1(wa, wb, sm, lat, fl);
            n_checks++;
            if (fl !== efl || lat !== elat) begin
                n_fail++;
                $display("FAIL rand12 a=%h b=%h s=%0d flags %b lat %0d expected %b lat %0d",
                         wa, wb, sm, fl, lat, efl, elat);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed_early();
        test_hold_and_ignore();
        test_wide_fixed();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
